// File: rtl/dp_ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a single-clock two-port RAM macro.
// A 2-entry register buffer hides the 1-cycle RAM read latency so push and pop can both run every cycle.
module dp_ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic [ADDR_WIDTH-1:0] ram_AA,
    output logic                  ram_CEA,
    output logic [ADDR_WIDTH-1:0] ram_AB,
    output logic                  ram_CEB,
    output logic [DATA_WIDTH-1:0] ram_DB,
    output logic [DATA_WIDTH-1:0] ram_BWB,
    input  logic [DATA_WIDTH-1:0] ram_QA
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam int OBUF_DEPTH = 2;

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0]   ram_count_reg;
    logic [ADDR_WIDTH:0]   ram_count_next;
    logic                  inflight_reg;
    logic [1:0]            obuf_cnt_reg;
    logic [1:0]            obuf_cnt_next;
    logic [1:0]            obuf_wr_idx;
    logic [DATA_WIDTH-1:0] obuf_reg  [OBUF_DEPTH];
    logic [DATA_WIDTH-1:0] obuf_next [OBUF_DEPTH];
    logic                  push;
    logic                  pop;
    logic [2:0]            pending;

    assign wr_ready = (ram_count_reg != DEPTH);
    assign push     = wr_valid & wr_ready;
    assign ram_CEB  = push;
    assign ram_AB   = wr_ptr_reg;
    assign ram_DB   = wr_data;
    assign ram_BWB  = '1;

    assign rd_valid = (obuf_cnt_reg != 2'd0);
    assign rd_data  = obuf_reg[0];
    assign pop      = rd_valid & rd_ready;

    // Only issue a read if the buffer will have room for its data next cycle.
    assign pending  = 3'(obuf_cnt_reg) + 3'(inflight_reg) - 3'(pop);
    assign ram_CEA  = (ram_count_reg != '0) && (pending < 3'd2);
    assign ram_AA   = rd_ptr_reg;

    assign count = {1'b0, ram_count_reg}
                 + (ADDR_WIDTH+2)'(inflight_reg)
                 + (ADDR_WIDTH+2)'(obuf_cnt_reg);

    always_comb begin
        ram_count_next = ram_count_reg;
        if (push && !ram_CEA) begin
            ram_count_next = ram_count_reg + (ADDR_WIDTH+1)'(1);
        end else if (!push && ram_CEA) begin
            ram_count_next = ram_count_reg - (ADDR_WIDTH+1)'(1);
        end
    end

    assign obuf_cnt_next = obuf_cnt_reg + 2'(inflight_reg) - 2'(pop);
    // Returning data lands in the first slot left free after this cycle's pop shift.
    assign obuf_wr_idx   = obuf_cnt_reg - 2'(pop);

    generate
        for (genvar gi = 0; gi < OBUF_DEPTH; gi++) begin : g_obuf
            logic [DATA_WIDTH-1:0] shift_in;
            if (gi < OBUF_DEPTH - 1) begin : g_shift
                assign shift_in = obuf_reg[gi+1];
            end else begin : g_hold
                assign shift_in = obuf_reg[gi];
            end
            assign obuf_next[gi] = (inflight_reg && (obuf_wr_idx == 2'(gi))) ? ram_QA :
                                   pop ? shift_in : obuf_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ram_count_reg <= '0;
            inflight_reg  <= 1'b0;
            obuf_cnt_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
            end
            if (ram_CEA) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
            end
            ram_count_reg <= ram_count_next;
            inflight_reg  <= ram_CEA;
            obuf_cnt_reg  <= obuf_cnt_next;
        end
    end

    always_ff @(posedge CLK) begin
        obuf_reg <= obuf_next;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (obuf_cnt_reg <= 2'd2);
        end
    end

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Bench for dp_ram_fifo_ctrl: behavioural RAM model, push-side scoreboard and a separate pop monitor.
module tb_dp_ram_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int MAXC  = 18;

    logic          CLK;
    logic          RST;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW+1:0] count;
    logic [AW-1:0] ram_AA;
    logic          ram_CEA;
    logic [AW-1:0] ram_AB;
    logic          ram_CEB;
    logic [DW-1:0] ram_DB;
    logic [DW-1:0] ram_BWB;
    logic [DW-1:0] ram_QA;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_d;
    logic [AW-1:0] exp_wptr;
    int            exp_count;
    int            checks;
    int            errors;
    int            n_pop;
    bit            verbose;

    dp_ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .ram_AA   (ram_AA),
        .ram_CEA  (ram_CEA),
        .ram_AB   (ram_AB),
        .ram_CEB  (ram_CEB),
        .ram_DB   (ram_DB),
        .ram_BWB  (ram_BWB),
        .ram_QA   (ram_QA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM macro model: 1-cycle read latency, output held between reads.
    always @(posedge CLK) begin
        if (ram_CEB) mem[ram_AB] <= ram_DB;
        if (ram_CEA) ram_QA <= mem[ram_AA];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Push side: log accepted entries, track expected occupancy and write port.
    always @(negedge CLK) begin
        if (RST) begin
            exp_q.delete();
            exp_count = 0;
            exp_wptr  = '0;
        end else begin
            chk("count", 32'(count), 32'(exp_count));
            chk("count_le_max", 32'(count <= (AW+2)'(MAXC)), 32'd1);
            if (ram_CEA && ram_CEB) chk("no_collision", 32'(ram_AA != ram_AB), 32'd1);
            chk("ram_CEB", 32'(ram_CEB), 32'(wr_valid && wr_ready));
            if (wr_valid && wr_ready) begin
                chk("ram_AB", 32'(ram_AB), 32'(exp_wptr));
                chk("ram_DB", ram_DB, wr_data);
                exp_q.push_back(wr_data);
                exp_wptr = exp_wptr + AW'(1);
            end
            exp_count = exp_count + int'(wr_valid && wr_ready) - int'(rd_valid && rd_ready);
        end
    end

    // Pop monitor: compare every popped head against the scoreboard.
    always @(negedge CLK) begin
        if (!RST && rd_valid && rd_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_empty got=%0h expected=none", rd_data);
            end else begin
                exp_d = exp_q.pop_front();
                chk("rd_data", rd_data, exp_d);
                if (verbose) $display("pop data=%08h count=%0d", rd_data, count);
            end
        end
    end

    task automatic drain();
        @(posedge CLK);
        #1;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge CLK);
            if (count == '0 && !rd_valid) break;
        end
        chk("drain_done", 32'(count == '0 && !rd_valid), 32'd1);
    endtask

    initial begin
        int acc;
        int base;
        checks   = 0;
        errors   = 0;
        n_pop    = 0;
        verbose  = 1'b1;
        RST      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("ram_BWB", ram_BWB, 32'hFFFF_FFFF);

        // Single push latency
        @(posedge CLK); #1;
        wr_valid = 1'b1; wr_data = 32'hA5A5_0001; rd_ready = 1'b1;
        @(negedge CLK);
        chk("single_CEB", 32'(ram_CEB), 32'd1);
        chk("single_AB", 32'(ram_AB), 32'd0);
        @(posedge CLK); #1;
        wr_valid = 1'b0;
        @(negedge CLK);
        chk("single_CEA", 32'(ram_CEA), 32'd1);
        chk("single_AA", 32'(ram_AA), 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("single_t2_rd_valid", 32'(rd_valid), 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("single_t3_rd_valid", 32'(rd_valid), 32'd1);
        chk("single_t3_rd_data", rd_data, 32'hA5A5_0001);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("single_t4_count", 32'(count), 32'd0);

        // Fill with no pops: 18 of 20 pushes fit
        acc = 0;
        for (int v = 0; v < 20; v++) begin
            @(posedge CLK); #1;
            rd_ready = 1'b0; wr_valid = 1'b1; wr_data = DW'(v);
            @(negedge CLK);
            chk("fill_wr_ready", 32'(wr_ready), 32'(v < MAXC));
            if (wr_ready) acc++;
        end
        @(posedge CLK); #1;
        wr_valid = 1'b0;
        @(negedge CLK);
        chk("fill_accepted", 32'(acc), 32'd18);
        chk("fill_count", 32'(count), 32'd18);
        chk("fill_wr_ready_full", 32'(wr_ready), 32'd0);
        base = n_pop;
        drain();
        chk("fill_pops", 32'(n_pop - base), 32'd18);

        // Continuous streaming: no bubbles after the 3-cycle fill
        base = n_pop;
        for (int i = 0; i < 103; i++) begin
            @(posedge CLK); #1;
            wr_valid = (i < 100); wr_data = DW'(1000 + i); rd_ready = 1'b1;
            @(negedge CLK);
            if (i < 100) chk("stream_wr_ready", 32'(wr_ready), 32'd1);
            if (i >= 3) chk("stream_rd_valid", 32'(rd_valid), 32'd1);
        end
        drain();
        chk("stream_pops", 32'(n_pop - base), 32'd100);

        // Full FIFO, simultaneous push and pop
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            rd_ready = 1'b0; wr_valid = 1'b1; wr_data = DW'(32'hF000 + k);
            @(negedge CLK);
            if (count == (AW+2)'(MAXC)) break;
        end
        chk("full_count", 32'(count), 32'd18);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        @(posedge CLK); #1;
        rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 32'hBEEF_0001;
        @(negedge CLK);
        chk("full_pushpop_refused", 32'(wr_ready), 32'd0);
        @(posedge CLK); #1;
        rd_ready = 1'b0;
        @(negedge CLK);
        chk("full_retry_ready", 32'(wr_ready), 32'd1);
        @(posedge CLK); #1;
        wr_valid = 1'b0;
        @(negedge CLK);
        chk("full_count_after", 32'(count), 32'd18);
        drain();

        // Random handshakes, 2000 entries
        verbose = 1'b0;
        acc = 0;
        for (int c = 0; c < 20000 && acc < 2000; c++) begin
            @(posedge CLK); #1;
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = $urandom;
            rd_ready = 1'($urandom_range(0, 1));
            @(negedge CLK);
            if (wr_valid && wr_ready) acc++;
        end
        chk("random_accepted", 32'(acc), 32'd2000);
        drain();
        verbose = 1'b1;

        // Reset while a read is in flight
        @(posedge CLK); #1;
        wr_valid = 1'b1; wr_data = 32'h5EED_0001; rd_ready = 1'b1;
        @(posedge CLK); #1;
        wr_valid = 1'b0; RST = 1'b1;
        @(negedge CLK);
        chk("rif_CEA", 32'(ram_CEA), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("rif_rd_valid", 32'(rd_valid), 32'd0);
            chk("rif_count", 32'(count), 32'd0);
            @(posedge CLK); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
